dice_roll_monitor: RTL and testbench
====================================

// Module: dice_roll_monitor
// PURPOSE
//  Receive-side companion of the dice display driver. Samples the 7-segment bus and the roll switch.
//  After each roll it waits for the segments to settle, decodes the pattern back to a face value 1..6,
//  and keeps per-face roll statistics. Used for on-board self-check of the dice and for fairness histograms.
// PARAMETERS
//  STABLE_CYCLES  16      consecutive CLK cycles of an unchanged synced Dseg before a decode (>=1)
//  TIMEOUT_CYCLES 100000  max cycles in SETTLE before a timeout error (> STABLE_CYCLES)
//  CNT_W          16      width of every statistics counter
// PORTS
//  CLK         in   1      system clock
//  RST         in   1      asynchronous, active-high reset
//  Switch      in   1      roll switch, asynchronous to CLK
//  Dseg        in   7      segment bus {a,b,c,d,e,f,g}, active-low, asynchronous to CLK
//  clr_stats   in   1      synchronous clear of all statistics counters
//  rd_sel      in   3      histogram read select, 1..6 (0 and 7 read as 0)
//  rd_count    out  CNT_W  combinational read of hist[rd_sel]
//  face_valid  out  1      1-cycle pulse: a roll was decoded
//  face        out  3      last decoded face 1..6; held until the next face_valid
//  err         out  1      1-cycle pulse: invalid pattern or timeout
//  err_timeout out  1      qualifies err: 1 = timeout, 0 = invalid pattern
//  total_rolls out  CNT_W  count of valid decodes
//  err_count   out  CNT_W  count of err pulses
// BEHAVIOUR
//  Reset (async, RST=1): state IDLE; all counters, hist[1..6], face, face_valid, err, err_timeout = 0;
//   synchronizers and the edge register = 0.
//  Sync: Switch and Dseg each pass through 2 flops. A rise on swS is detected one register later.
//  Segment decode (active-low): 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5,
//   0100000->6. Any other pattern is invalid.
//  FSM:
//   IDLE   - on a swS rise: clear stab_cnt and tmo_cnt; go to SETTLE.
//   SETTLE - each cycle tmo_cnt++.
//          - If synced Dseg differs from its previous-cycle value: stab_cnt=0; else stab_cnt++.
//          - When stab_cnt reaches STABLE_CYCLES: decode, then go to IDLE.
//              valid   -> face_valid=1, face updated, hist[face]++, total_rolls++
//              invalid -> err=1, err_timeout=0, err_count++
//          - If tmo_cnt reaches TIMEOUT_CYCLES first: err=1, err_timeout=1, err_count++; go to IDLE.
//          - A new swS rise in SETTLE restarts both counters (retrigger). No event is produced for it.
//  Latency: Switch first sampled high at edge k, Dseg steady -> face_valid is high in the cycle
//   after edge k+2+STABLE_CYCLES.
//  Pulses: face_valid and err are registered and last exactly 1 cycle. They are never high together.
//  Counters: saturate at all-ones and never wrap.
//  clr_stats: zeroes hist, total_rolls and err_count.
//   - Takes priority over a same-cycle increment; that event's stat update is dropped.
//   - The face_valid/err pulse is still emitted.
//   - Does not affect the FSM or face.
//  Mid-operation RST: aborts SETTLE with no pulse. Statistics return to 0.
//  A Switch held high or bouncing produces one roll per clean rise. Retriggers while in SETTLE are absorbed.
// STRUCTURE
//  dice_pkg: SEG_FACE1..SEG_FACE6 localparams; face_t (logic [2:0]);
//   state_t enum {IDLE, SETTLE}; seg_to_face() function returning face_t, 0 = invalid.
//  Sub-module dice_sync2 #(W): 2-flop synchronizer with async active-high reset.
//   Instantiated for Switch (W=1) and Dseg (W=7).
//  Top level holds the FSM, the stability and timeout counters, the histogram array and the statistics.
// TESTING
//  1. Dseg=0010010 held, pulse Switch -> one face_valid, face=2, hist[2]=1, total_rolls=1,
//     latency = STABLE_CYCLES+3 edges.
//  2. Six rolls showing faces 1..6 in turn -> rd_sel=1..6 each read 1; total_rolls=6; err_count=0.
//  3. Dseg=1111111 held, roll -> err=1, err_timeout=0, err_count=1, hist and face unchanged.
//  4. Dseg toggling every 4 cycles for longer than TIMEOUT_CYCLES (set to 200), roll
//     -> err=1 with err_timeout=1 at tmo_cnt=200.
//  5. Second Switch rise 5 cycles into SETTLE -> exactly one face_valid, STABLE_CYCLES+3 edges after the 2nd rise.
//  6. clr_stats in the same cycle as a face_valid -> pulse seen, total_rolls=0.
//     Also: with CNT_W=4, 20 rolls -> total_rolls=15.
//     Also: RST asserted in SETTLE -> no pulse and all outputs 0.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types, segment patterns and the segment-to-face decoder for the dice roll monitor.
package dice_pkg;

  typedef logic [2:0] face_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_FACE1 = 7'b1001111;
  localparam logic [6:0] SEG_FACE2 = 7'b0010010;
  localparam logic [6:0] SEG_FACE3 = 7'b0000110;
  localparam logic [6:0] SEG_FACE4 = 7'b1001100;
  localparam logic [6:0] SEG_FACE5 = 7'b0100100;
  localparam logic [6:0] SEG_FACE6 = 7'b0100000;

  // Returns 1..6 for a recognised face, 0 for any other pattern.
  function automatic face_t seg_to_face(input logic [6:0] seg);
    face_t f;
    case (seg)
      SEG_FACE1: f = 3'd1;
      SEG_FACE2: f = 3'd2;
      SEG_FACE3: f = 3'd3;
      SEG_FACE4: f = 3'd4;
      SEG_FACE5: f = 3'd5;
      SEG_FACE6: f = 3'd6;
      default:   f = 3'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dice_sync2.sv
// Two-flop synchronizer for asynchronous inputs, asynchronous active-high reset.
module dice_sync2 #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability filter chain
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= {W{1'b0}};
      r_sync <= {W{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dice_roll_monitor.sv
// Samples the dice display bus after each roll, decodes the settled face and keeps
// per-face histograms plus roll and error statistics.
module dice_roll_monitor
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Switch,
  input  logic [6:0]       Dseg,
  input  logic             clr_stats,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic             face_valid,
  output logic [2:0]       face,
  output logic             err,
  output logic             err_timeout,
  output logic [CNT_W-1:0] total_rolls,
  output logic [CNT_W-1:0] err_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic              w_sw_s;
  logic [6:0]        w_seg_s;
  logic              r_sw_prev;
  logic [6:0]        r_seg_prev;
  logic              w_sw_rise;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic              w_ev_decode;
  logic              w_ev_tmo;
  logic              w_ev_valid;
  logic              w_ev_err;
  face_t             w_dec_face;
  logic [CNT_W-1:0]  r_hist [1:6];

  dice_sync2 #(.W(1)) u_sync_sw (
    .CLK (CLK),
    .RST (RST),
    .i_d (Switch),
    .o_q (w_sw_s)
  );

  dice_sync2 #(.W(7)) u_sync_seg (
    .CLK (CLK),
    .RST (RST),
    .i_d (Dseg),
    .o_q (w_seg_s)
  );

  assign w_sw_rise  = w_sw_s & ~r_sw_prev;
  assign w_dec_face = seg_to_face(w_seg_s);
  assign w_ev_valid = w_ev_decode & (w_dec_face != 3'd0);
  assign w_ev_err   = (w_ev_decode & (w_dec_face == 3'd0)) | w_ev_tmo;

  // Edge and previous-segment history registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sw_prev  <= 1'b0;
      r_seg_prev <= 7'b0000000;
    end else begin
      r_sw_prev  <= w_sw_s;
      r_seg_prev <= w_seg_s;
    end
  end

  // FSM state and settle counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_stab_cnt <= {STAB_W{1'b0}};
      r_tmo_cnt  <= {TMO_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
    end
  end

  // Next state; a stable decode wins over a timeout landing in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    w_ev_decode = 1'b0;
    w_ev_tmo    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sw_rise) begin
          w_stab_nxt  = {STAB_W{1'b0}};
          w_tmo_nxt   = {TMO_W{1'b0}};
          w_state_nxt = SETTLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (w_sw_rise) begin
          w_stab_nxt = {STAB_W{1'b0}};
          w_tmo_nxt  = {TMO_W{1'b0}};
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
          if (w_seg_s != r_seg_prev) begin
            w_stab_nxt = {STAB_W{1'b0}};
          end else begin
            w_stab_nxt = r_stab_cnt + STAB_W'(1);
          end
          if (w_stab_nxt == STAB_MAX) begin
            w_ev_decode = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_tmo_nxt == TMO_MAX) begin
            w_ev_tmo    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SETTLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Event pulses, held face and statistics; clr_stats drops a same-cycle increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      face_valid  <= 1'b0;
      err         <= 1'b0;
      err_timeout <= 1'b0;
      face        <= 3'd0;
      total_rolls <= {CNT_W{1'b0}};
      err_count   <= {CNT_W{1'b0}};
      for (int i = 1; i <= 6; i++) r_hist[i] <= {CNT_W{1'b0}};
    end else begin
      face_valid <= w_ev_valid;
      err        <= w_ev_err;
      if (w_ev_valid) face <= w_dec_face;
      if (w_ev_err) err_timeout <= w_ev_tmo;
      if (clr_stats) begin
        total_rolls <= {CNT_W{1'b0}};
        err_count   <= {CNT_W{1'b0}};
        for (int i = 1; i <= 6; i++) r_hist[i] <= {CNT_W{1'b0}};
      end else begin
        if (w_ev_valid) begin
          total_rolls <= sat_inc(total_rolls);
          case (w_dec_face)
            3'd1:    r_hist[1] <= sat_inc(r_hist[1]);
            3'd2:    r_hist[2] <= sat_inc(r_hist[2]);
            3'd3:    r_hist[3] <= sat_inc(r_hist[3]);
            3'd4:    r_hist[4] <= sat_inc(r_hist[4]);
            3'd5:    r_hist[5] <= sat_inc(r_hist[5]);
            3'd6:    r_hist[6] <= sat_inc(r_hist[6]);
            default: ;
          endcase
        end
        if (w_ev_err) err_count <= sat_inc(err_count);
      end
    end
  end

  // Histogram read mux; selects 0 and 7 read as zero
  always_comb begin
    rd_count = {CNT_W{1'b0}};
    case (rd_sel)
      3'd1:    rd_count = r_hist[1];
      3'd2:    rd_count = r_hist[2];
      3'd3:    rd_count = r_hist[3];
      3'd4:    rd_count = r_hist[4];
      3'd5:    rd_count = r_hist[5];
      3'd6:    rd_count = r_hist[6];
      default: rd_count = {CNT_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_dice_roll_monitor.sv
// Directed, table-driven bench for dice_roll_monitor plus hand-written multi-cycle sequences.
module tb_dice_roll_monitor;

  localparam int S = 16;
  localparam int T = 200;
  localparam int LAT = S + 3;

  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;

  logic        CLK, RST, Switch, clr_stats, clr4;
  logic [6:0]  Dseg;
  logic [2:0]  rd_sel, rd_sel4;
  logic [15:0] rd_count, total_rolls, err_count;
  logic        face_valid, err, err_timeout;
  logic [2:0]  face;
  logic [3:0]  rd_count4, total_rolls4, err_count4;
  logic        face_valid4, err4, err_timeout4;
  logic [2:0]  face4;

  int compared = 0;
  int mismatched = 0;

  dice_roll_monitor #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Switch(Switch), .Dseg(Dseg), .clr_stats(clr_stats),
    .rd_sel(rd_sel), .rd_count(rd_count), .face_valid(face_valid), .face(face),
    .err(err), .err_timeout(err_timeout), .total_rolls(total_rolls), .err_count(err_count)
  );

  dice_roll_monitor #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .Switch(Switch), .Dseg(Dseg), .clr_stats(clr4),
    .rd_sel(rd_sel4), .rd_count(rd_count4), .face_valid(face_valid4), .face(face4),
    .err(err4), .err_timeout(err_timeout4), .total_rolls(total_rolls4), .err_count(err_count4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [6:0] seg;
    logic       exp_valid;
    logic [2:0] exp_face;
  } vec_t;

  vec_t vecs [9];
  int exp_hist [1:6];
  int exp_total, exp_err;
  logic [2:0] exp_face;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one roll and wait (bounded) for face_valid or err.
  task automatic roll_wait(input logic [6:0] seg, output int n, output logic gv, output logic ge,
                           output logic [2:0] gf, output logic gt);
    logic got;
    got = 1'b0; n = 0; gv = 1'b0; ge = 1'b0; gf = 3'd0; gt = 1'b0;
    Dseg = seg;
    Switch = 1'b1;
    while (!got && n < 400) begin
      @(posedge CLK); #1;
      n++;
      if (n == 3) Switch = 1'b0;
      if (face_valid || err) begin
        got = 1'b1; gv = face_valid; ge = err; gf = face; gt = err_timeout;
        chk("pulse_exclusive", {31'd0, face_valid & err}, 32'd0);
      end
    end
    Switch = 1'b0;
    if (!got) chk("event_wait_bound", 32'd0, 32'd1);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic check_hist(input string tag);
    for (int f = 1; f <= 6; f++) begin
      rd_sel = 3'(f); #1;
      chk(tag, {16'd0, rd_count}, exp_hist[f]);
    end
    rd_sel = 3'd0; #1; chk("rd_sel0", {16'd0, rd_count}, 32'd0);
    rd_sel = 3'd7; #1; chk("rd_sel7", {16'd0, rd_count}, 32'd0);
  endtask

  int n, pulses, lat;
  logic gv, ge, gt;
  logic [2:0] gf;

  initial begin
    vecs[0] = '{P1, 1'b1, 3'd1};
    vecs[1] = '{P2, 1'b1, 3'd2};
    vecs[2] = '{P3, 1'b1, 3'd3};
    vecs[3] = '{P4, 1'b1, 3'd4};
    vecs[4] = '{P5, 1'b1, 3'd5};
    vecs[5] = '{P6, 1'b1, 3'd6};
    vecs[6] = '{7'b1111111, 1'b0, 3'd0};
    vecs[7] = '{7'b0000000, 1'b0, 3'd0};
    vecs[8] = '{P6, 1'b1, 3'd6};
    for (int f = 1; f <= 6; f++) exp_hist[f] = 0;
    exp_total = 0; exp_err = 0; exp_face = 3'd0;

    RST = 1'b1; Switch = 1'b0; Dseg = 7'b1111111; clr_stats = 1'b0; clr4 = 1'b0;
    rd_sel = 3'd2; rd_sel4 = 3'd5;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_face_valid", {31'd0, face_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_face", {29'd0, face}, 32'd0);
    chk("rst_total", {16'd0, total_rolls}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Single roll of face 2 with latency measurement
    roll_wait(P2, n, gv, ge, gf, gt);
    chk("t1_latency", n, LAT);
    chk("t1_valid", {31'd0, gv}, 32'd1);
    chk("t1_face", {29'd0, gf}, 32'd2);
    rd_sel = 3'd2; #1;
    chk("t1_hist2", {16'd0, rd_count}, 32'd1);
    chk("t1_total", {16'd0, total_rolls}, 32'd1);

    // Clear stats while idle
    clr_stats = 1'b1; @(posedge CLK); #1; clr_stats = 1'b0;
    chk("clr_total", {16'd0, total_rolls}, 32'd0);
    chk("clr_hist2", {16'd0, rd_count}, 32'd0);
    exp_face = 3'd2;

    // Table-driven rolls
    for (int i = 0; i < 9; i++) begin
      roll_wait(vecs[i].seg, n, gv, ge, gf, gt);
      if (vecs[i].exp_valid) begin
        exp_face = vecs[i].exp_face;
        exp_hist[vecs[i].exp_face]++;
        exp_total++;
      end else begin
        exp_err++;
      end
      chk("tbl_latency", n, LAT);
      chk("tbl_valid", {31'd0, gv}, {31'd0, vecs[i].exp_valid});
      chk("tbl_err", {31'd0, ge}, {31'd0, ~vecs[i].exp_valid});
      chk("tbl_face", {29'd0, gf}, {29'd0, exp_face});
      chk("tbl_err_timeout", {31'd0, gt}, 32'd0);
      if (i == 5) begin
        check_hist("t2_hist");
        chk("t2_total", {16'd0, total_rolls}, 32'd6);
        chk("t2_err_count", {16'd0, err_count}, 32'd0);
      end
    end
    check_hist("tbl_hist");
    chk("tbl_total", {16'd0, total_rolls}, exp_total);
    chk("tbl_err_count", {16'd0, err_count}, exp_err);

    // Timeout: segments never settle
    fork
      roll_wait(P2, n, gv, ge, gf, gt);
      begin
        for (int i = 0; i < 65; i++) begin
          repeat (4) @(negedge CLK);
          Dseg = (Dseg == P2) ? P3 : P2;
        end
      end
    join
    exp_err++;
    chk("tmo_latency", n, T + 3);
    chk("tmo_err", {31'd0, ge}, 32'd1);
    chk("tmo_valid", {31'd0, gv}, 32'd0);
    chk("tmo_err_timeout", {31'd0, gt}, 32'd1);
    chk("tmo_face_held", {29'd0, gf}, {29'd0, exp_face});
    chk("tmo_err_count", {16'd0, err_count}, exp_err);
    Dseg = P4;
    repeat (4) @(posedge CLK);
    #1;

    // Retrigger: second rise during SETTLE
    pulses = 0; lat = -1;
    Switch = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge CLK); #1;
      if (k == 2) Switch = 1'b0;
      if (k == 6) Switch = 1'b1;
      if (k == 9) Switch = 1'b0;
      if (face_valid) begin pulses++; lat = k - 6; end
      if (err) pulses++;
    end
    chk("retrig_pulses", pulses, 32'd1);
    chk("retrig_latency", lat, LAT);
    chk("retrig_face", {29'd0, face}, 32'd4);

    // clr_stats coincident with face_valid
    Dseg = P3;
    Switch = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge CLK); #1;
      if (k == 3) Switch = 1'b0;
      if (k == LAT - 1) clr_stats = 1'b1;
    end
    chk("clr_pulse", {31'd0, face_valid}, 32'd1);
    chk("clr_face", {29'd0, face}, 32'd3);
    chk("clr_total_same_cycle", {16'd0, total_rolls}, 32'd0);
    chk("clr_err_count", {16'd0, err_count}, 32'd0);
    clr_stats = 1'b0;
    rd_sel = 3'd3; #1;
    chk("clr_hist3", {16'd0, rd_count}, 32'd0);
    repeat (4) @(posedge CLK);
    #1;

    // RST in the middle of SETTLE
    Dseg = P1;
    Switch = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      if (k == 3) Switch = 1'b0;
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("mrst_face", {29'd0, face}, 32'd0);
    chk("mrst_face_valid", {31'd0, face_valid}, 32'd0);
    chk("mrst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("mrst_total4", {28'd0, total_rolls4}, 32'd0);
    RST = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (face_valid || err) pulses++;
    end
    chk("mrst_no_pulse", pulses, 32'd0);

    // Saturation on the 4-bit instance
    for (int r = 0; r < 20; r++) roll_wait(P5, n, gv, ge, gf, gt);
    rd_sel = 3'd5; rd_sel4 = 3'd5; #1;
    chk("sat_total4", {28'd0, total_rolls4}, 32'd15);
    chk("sat_hist5_4", {28'd0, rd_count4}, 32'd15);
    chk("sat_total16", {16'd0, total_rolls}, 32'd20);
    chk("sat_hist5_16", {16'd0, rd_count}, 32'd20);
    chk("sat_err4", {28'd0, err_count4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
